// File: rtl/stream_demux_n_if.sv
// Stream demux bus: one producer port and N registered consumer lanes.
// The master side drives words in and takes lanes out; the slave side is the demux.
interface stream_demux_n_if #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 8,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 8
);
    logic [DATA_W-1:0]       in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_bcast;
    logic                    in_valid;
    logic                    in_ready;
    logic [N_OUT*DATA_W-1:0] out_data;
    logic [N_OUT-1:0]        out_valid;
    logic [N_OUT-1:0]        out_ready;
    logic [CNT_W-1:0]        drop_cnt;

    modport master (
        output in_data,
        output in_sel,
        output in_bcast,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  drop_cnt
    );

    modport slave (
        input  in_data,
        input  in_sel,
        input  in_bcast,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output drop_cnt
    );
endinterface

// File: rtl/stream_demux_n.sv
// 1:N stream demultiplexer with one registered slot per lane, broadcast
// mode and a saturating counter for words whose select is out of range.
module stream_demux_n #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 8,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 8
) (
    input logic             clk,
    input logic             rst_n,
    stream_demux_n_if.slave bus
);

    logic [DATA_W-1:0]       r_data [N_OUT];
    logic [N_OUT-1:0]        r_valid;
    logic [CNT_W-1:0]        r_drop;

    logic [N_OUT-1:0]        w_free;
    logic [N_OUT-1:0]        w_hit;
    logic [N_OUT-1:0]        w_load;
    logic                    w_sel_ok;
    logic                    w_in_ready;
    logic                    w_acc;
    logic                    w_drop;
    logic [N_OUT*DATA_W-1:0] w_out_data;

    // A slot draining this cycle can take a new word on the same edge.
    assign w_free = ~r_valid | bus.out_ready;

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < N_OUT; i++) begin
            w_hit[i] = ({1'b0, bus.in_sel} == (SEL_W+1)'(i));
        end
    end

    assign w_sel_ok = |w_hit;

    always_comb begin
        w_in_ready = 1'b1;
        unique case (1'b1)
            bus.in_bcast:
                w_in_ready = &w_free;
            !bus.in_bcast && w_sel_ok:
                w_in_ready = |(w_hit & w_free);
            !bus.in_bcast && !w_sel_ok:
                w_in_ready = 1'b1;
            default:
                w_in_ready = 1'b1;
        endcase
    end

    assign w_acc  = bus.in_valid & w_in_ready;
    assign w_load = {N_OUT{w_acc}} & ({N_OUT{bus.in_bcast}} | w_hit);
    assign w_drop = w_acc & ~bus.in_bcast & ~w_sel_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < N_OUT; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (w_load[i]) begin
                    r_valid[i] <= 1'b1;
                    r_data[i]  <= bus.in_data;
                end else if (bus.out_ready[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Saturate rather than wrap so a flood of bad selects stays visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != {CNT_W{1'b1}})) begin
            r_drop <= r_drop + 1'b1;
        end
    end

    always_comb begin
        w_out_data = '0;
        for (int i = 0; i < N_OUT; i++) begin
            w_out_data[i*DATA_W +: DATA_W] = r_data[i];
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = w_out_data;
    assign bus.drop_cnt  = r_drop;

endmodule
